fetch_pc_unit: RTL and testbench

- Program-counter and instruction-fetch stage directly upstream of the control unit and datapath.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents the fetched instruction with PC and PC+4 to the decode side, marked by a valid flag.
- Consumes the resolved 2-bit PCsrc (plus ImmExt and ALUResult) to pick the next PC, and traps on misaligned targets.

---
 rtl/fetch_pc_unit.sv | 98 +++++++++
 tb/tb_fetch_pc_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: fetches one word per instruction over a
// req/ready handshake, holds it for decode, then steers the PC from the resolved PCsrc.
module fetch_pc_unit #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [1:0]            PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCPlus4,
  output logic                  valid_out,
  output logic                  trap
);

  localparam logic [DATA_WIDTH-1:0] Four = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] Nop  = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StTrap} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q, pc4_q, instr_q;
  logic                  valid_q, req_q, trap_q;
  logic [DATA_WIDTH-1:0] target_d;

  // Code 11 is reserved and falls back to sequential flow.
  always_comb begin
    target_d = pc_q + Four;
    unique case (PCsrc)
      2'b01:   target_d = pc_q + ImmExt;
      2'b10:   target_d = ALUResult & ~DATA_WIDTH'(1);
      default: target_d = pc_q + Four;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + Four;
      instr_q <= Nop;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          req_q   <= 1'b1;
          state_q <= StFetch;
        end
        StFetch: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (!stall) begin
            valid_q <= 1'b0;
            if (target_d[1:0] == 2'b00) begin
              pc_q    <= target_d;
              pc4_q   <= target_d + Four;
              req_q   <= 1'b1;
              state_q <= StFetch;
            end else begin
              trap_q  <= 1'b1;
              state_q <= StTrap;
            end
          end
        end
        StTrap: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign Instr     = instr_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc4_q;
  assign valid_out = valid_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a transaction-level PC model drives expected
// fetch addresses, instruction words, redirects and traps.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready;
  logic [1:0]  PCsrc;
  logic [31:0] ImmExt, ALUResult, imem_rdata;
  logic        imem_req, valid_out, trap;
  logic [31:0] imem_addr, Instr, PC, PCPlus4;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] pc_m;
  bit          trapped;

  localparam logic [31:0] Nop = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .PCsrc      (PCsrc),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .valid_out  (valid_out),
    .trap       (trap)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (imem_req && valid_out) begin
        n_err++;
        $display("FAIL invariant: req=%0b valid=%0b, required not both 1", imem_req, valid_out);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Entry: DUT in fetch state. Exit: instruction presented for issue.
  task automatic do_fetch(input logic [31:0] exp_pc, input int unsigned waits);
    for (int i = 0; i <= int'(waits); i++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL fetch_req: req=%0b addr=%h valid=%0b, required 1/%h/0",
                 imem_req, imem_addr, valid_out, exp_pc);
      end
      imem_ready = (i == int'(waits));
      step();
    end
    imem_ready = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b1 || imem_req !== 1'b0 || Instr !== mem_word(exp_pc) ||
        PC !== exp_pc || PCPlus4 !== exp_pc + 32'd4) begin
      n_err++;
      $display("FAIL fetch_data: valid=%0b req=%0b instr=%h pc=%h pc4=%h, required 1/0/%h/%h/%h",
               valid_out, imem_req, Instr, PC, PCPlus4, mem_word(exp_pc), exp_pc, exp_pc + 32'd4);
    end
  endtask

  // Entry: instruction presented. Stalls first, then one consume cycle checked against pc_m.
  task automatic do_issue(input int unsigned stalls, input logic [1:0] src,
                          input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] tgt;
    trapped = 1'b0;
    for (int i = 0; i < int'(stalls); i++) begin
      stall = 1'b1; PCsrc = (i % 2 == 0) ? 2'b01 : 2'b00; ImmExt = 32'd16;
      ALUResult = $urandom; imem_ready = 1'($urandom);
      step();
      n_cmp++;
      if (valid_out !== 1'b1 || imem_req !== 1'b0 || PC !== pc_m || Instr !== mem_word(pc_m) ||
          PCPlus4 !== pc_m + 32'd4) begin
        n_err++;
        $display("FAIL stall_hold: valid=%0b req=%0b pc=%h instr=%h, required 1/0/%h/%h",
                 valid_out, imem_req, PC, Instr, pc_m, mem_word(pc_m));
      end
    end
    stall = 1'b0; PCsrc = src; ImmExt = imm; ALUResult = alu; imem_ready = 1'($urandom);
    case (src)
      2'b01:   tgt = pc_m + imm;
      2'b10:   tgt = {alu[31:1], 1'b0};
      default: tgt = pc_m + 32'd4;
    endcase
    step();
    imem_ready = 1'b0;
    if (tgt[1:0] == 2'b00) begin
      n_cmp++;
      if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== tgt ||
          PCPlus4 !== tgt + 32'd4 || trap !== 1'b0) begin
        n_err++;
        $display("FAIL redirect: valid=%0b req=%0b addr=%h pc4=%h trap=%0b, required 0/1/%h/%h/0",
                 valid_out, imem_req, imem_addr, PCPlus4, trap, tgt, tgt + 32'd4);
      end
      pc_m = tgt;
    end else begin
      n_cmp++;
      if (trap !== 1'b1 || valid_out !== 1'b0 || imem_req !== 1'b0 || PC !== pc_m) begin
        n_err++;
        $display("FAIL trap_entry: trap=%0b valid=%0b req=%0b pc=%h, required 1/0/0/%h",
                 trap, valid_out, imem_req, PC, pc_m);
      end
      trapped = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; PCsrc = 2'b00; ImmExt = '0; ALUResult = '0;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (PC !== 32'h0 || PCPlus4 !== 32'h4 || Instr !== Nop || valid_out !== 1'b0 ||
        imem_req !== 1'b0 || trap !== 1'b0) begin
      n_err++;
      $display("FAIL reset: pc=%h pc4=%h instr=%h valid=%0b req=%0b trap=%0b, required 0/4/13/0/0/0",
               PC, PCPlus4, Instr, valid_out, imem_req, trap);
    end
    step();
    pc_m = 32'h0;
  endtask

  task automatic test_first_fetch();
    do_fetch(32'h0, 0);
    do_issue(0, 2'b00, $urandom, $urandom);
  endtask

  task automatic test_wait_states();
    do_fetch(32'h4, 3);
    do_issue(0, 2'b00, $urandom, $urandom);
  endtask

  task automatic test_stall();
    do_fetch(32'h8, 0);
    do_issue(5, 2'b00, 32'd16, $urandom);
  endtask

  task automatic test_redirect();
    do_fetch(32'hC, 0);
    do_issue(0, 2'b01, 32'h14, $urandom);
    do_fetch(32'h20, 1);
    do_issue(0, 2'b01, 32'hFFFF_FFF0, $urandom);
    do_fetch(32'h10, 0);
    do_issue(1, 2'b10, $urandom, 32'h101);
    do_fetch(32'h100, 2);
    do_issue(0, 2'b11, $urandom, $urandom);
    do_fetch(32'h104, 0);
  endtask

  task automatic test_wrap();
    do_issue(0, 2'b01, 32'hFFFF_FFFC - 32'h104, $urandom);
    do_fetch(32'hFFFF_FFFC, 0);
    do_issue(0, 2'b00, $urandom, $urandom);
    do_fetch(32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] imm, alu;
    for (int n = 0; n < 40; n++) begin
      imm = $urandom; alu = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        imm[1:0] = 2'b00;
        alu[1]   = 1'b0;
      end
      do_issue($urandom_range(0, 2), 2'($urandom), imm, alu);
      if (trapped) begin
        do_reset();
        step();
        pc_m = 32'h0;
      end
      do_fetch(pc_m, $urandom_range(0, 3));
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    pc_m = 32'h0;
    do_fetch(32'h0, 0);
    do_issue(0, 2'b01, 32'h40, $urandom);
    do_fetch(32'h40, 0);
    do_issue(0, 2'b01, 32'h6, $urandom);
    n_cmp++;
    if (trapped !== 1'b1) begin
      n_err++;
      $display("FAIL misaligned_model: trapped=%0b, required 1", trapped);
    end
    for (int i = 0; i < 6; i++) begin
      imem_ready = 1'($urandom); stall = 1'($urandom); PCsrc = 2'($urandom);
      step();
      n_cmp++;
      if (imem_req !== 1'b0 || valid_out !== 1'b0 || trap !== 1'b1 || PC !== 32'h40) begin
        n_err++;
        $display("FAIL trap_hold: req=%0b valid=%0b trap=%0b pc=%h, required 0/0/1/40",
                 imem_req, valid_out, trap, PC);
      end
    end
    do_reset();
    n_cmp++;
    if (PC !== 32'h0 || trap !== 1'b0 || valid_out !== 1'b0 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL trap_exit: pc=%h trap=%0b valid=%0b req=%0b, required 0/0/0/0",
               PC, trap, valid_out, imem_req);
    end
    step();
    pc_m = 32'h0;
    do_fetch(32'h0, 0);
  endtask

  task automatic test_reset_mid_fetch();
    do_issue(0, 2'b00, $urandom, $urandom);
    rst = 1'b1; imem_ready = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (Instr !== Nop || valid_out !== 1'b0 || imem_req !== 1'b0 || PC !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_fetch: instr=%h valid=%0b req=%0b pc=%h, required 13/0/0/0",
               Instr, valid_out, imem_req, PC);
    end
    step();
    imem_ready = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || Instr !== Nop) begin
      n_err++;
      $display("FAIL late_ready: valid=%0b req=%0b addr=%h instr=%h, required 0/1/0/13",
               valid_out, imem_req, imem_addr, Instr);
    end
    pc_m = 32'h0;
    do_fetch(32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_stall();
    test_redirect();
    test_wrap();
    test_random();
    test_misaligned();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
